// File: rtl/tlb_s1_port_ctrl.sv
// tlb_s1_port_ctrl
//   Shares TLB search port 1 between the EXE-stage load/store lookup and the
//   maintenance requester (tlbsrch / invtlb). Every access is a grant/response
//   handshake. A one-cycle fence follows each invtlb so that no lookup can
//   observe a pre-invalidate result. The block also produces the pseudo-random
//   tlbfill replacement index.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   flush             WB flush (exception / ertn / refetch)
//   lk_*              EXE lookup request, grant and registered response
//   mt_*              maintenance request, grant, done pulse, tlbsrch result
//   s1_*              search key driven to TLB port 1
//   invtlb_valid/op   invalidate command to the TLB
//   s1_result         TLB port-1 combinational result
//                     {found, index[3:0], ppn[19:0], ps[5:0], plv, mat, d, v}
//   fill_index        replacement index for tlbfill
module tlb_s1_port_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  // EXE lookup requester
  input  logic            lk_req,
  input  logic [18:0]     lk_vppn,
  input  logic            lk_va_bit12,
  input  logic [9:0]      lk_asid,
  output logic            lk_gnt,
  output logic            lk_rsp_valid,
  input  logic            lk_rsp_ready,
  output logic [36:0]     lk_rsp,
  // Maintenance requester
  input  logic            mt_req,
  input  logic            mt_is_inv,
  input  logic [4:0]      mt_invop,
  input  logic [9:0]      mt_asid,
  input  logic [18:0]     mt_vppn,
  input  logic            mt_va_bit12,
  output logic            mt_gnt,
  output logic            mt_done,
  output logic            mt_hit,
  output logic [IDXW-1:0] mt_index,
  // TLB port 1
  output logic [18:0]     s1_vppn,
  output logic            s1_va_bit12,
  output logic [9:0]      s1_asid,
  output logic            invtlb_valid,
  output logic [4:0]      invtlb_op,
  input  logic [36:0]     s1_result,
  // Replacement
  output logic [IDXW-1:0] fill_index
);

  typedef enum logic [1:0] {
    IDLE,
    LK_RSP,
    MT_RSP,
    FENCE
  } state_t;

  localparam logic [1:0]    STARVE_MAX  = 2'd3;
  localparam logic [IDXW:0] NUM_ENTRIES = (IDXW + 1)'(TLBNUM);

  state_t          state;
  logic            op_is_inv;   // remembers whether the op in flight was invtlb
  logic [1:0]      starve_cnt;
  logic [7:0]      lfsr;
  logic [18:0]     vppn_q;
  logic            va_bit12_q;
  logic [9:0]      asid_q;

  logic            idle;
  logic            lk_pick;
  logic [IDXW-1:0] lfsr_idx;

  // Arbitration: maintenance wins unless the lookup has been passed over
  // three times. A flush kills the lookup for this cycle only, which lets a
  // pending maintenance op through.
  assign idle    = (state == IDLE) && !reset;
  assign lk_pick = lk_req && !flush && (!mt_req || (starve_cnt == STARVE_MAX));
  assign lk_gnt  = idle && lk_pick;
  assign mt_gnt  = idle && mt_req && !lk_pick;

  assign invtlb_valid = mt_gnt && mt_is_inv;
  assign invtlb_op    = invtlb_valid ? mt_invop : 5'd0;

  // The TLB result is combinational from the key, so the key must reach the
  // port in the grant cycle itself; between grants the last key is held.
  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    s1_vppn     = vppn_q;
    s1_va_bit12 = va_bit12_q;
    s1_asid     = asid_q;
    if (lk_gnt) begin
      s1_vppn     = lk_vppn;
      s1_va_bit12 = lk_va_bit12;
      s1_asid     = lk_asid;
    end else if (mt_gnt) begin
      s1_vppn     = mt_vppn;
      s1_va_bit12 = mt_va_bit12;
      s1_asid     = mt_asid;
    end
  end

  // Folds the index back into range when TLBNUM is not a power of two.
  assign lfsr_idx   = lfsr[IDXW-1:0];
  assign fill_index = ({1'b0, lfsr_idx} < NUM_ENTRIES) ? lfsr_idx
                                                       : lfsr_idx - NUM_ENTRIES[IDXW-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_is_inv    <= 1'b0;
      starve_cnt   <= 2'd0;
      lfsr         <= 8'h01;
      vppn_q       <= '0;
      va_bit12_q   <= 1'b0;
      asid_q       <= '0;
      lk_rsp_valid <= 1'b0;
      lk_rsp       <= '0;
      mt_done      <= 1'b0;
      mt_hit       <= 1'b0;
      mt_index     <= '0;
    end else begin
      // x^8+x^6+x^5+x^4+1, shifting left; a non-zero seed never reaches zero.
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      mt_done <= 1'b0;

      if (lk_gnt || mt_gnt) begin
        vppn_q     <= s1_vppn;
        va_bit12_q <= s1_va_bit12;
        asid_q     <= s1_asid;
      end

      if (lk_gnt) begin
        starve_cnt <= 2'd0;
      end else if (mt_gnt && lk_req && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 2'd1;
      end

      case (state)
        IDLE: begin
          if (mt_gnt) begin
            state     <= MT_RSP;
            mt_done   <= 1'b1;
            mt_hit    <= s1_result[36];
            mt_index  <= s1_result[32 +: IDXW];
            op_is_inv <= mt_is_inv;
          end else if (lk_gnt) begin
            state        <= LK_RSP;
            lk_rsp_valid <= 1'b1;
            lk_rsp       <= s1_result;
          end
        end
        LK_RSP: begin
          // A flush drops the response without waiting for the consumer.
          if (lk_rsp_ready || flush) begin
            state        <= IDLE;
            lk_rsp_valid <= 1'b0;
          end
        end
        MT_RSP: begin
          // The op already reached the TLB, so flush does not cancel it.
          state <= op_is_inv ? FENCE : IDLE;
        end
        FENCE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_s1_port_ctrl.sv
// tb_tlb_s1_port_ctrl
//   Drives directed scenarios into tlb_s1_port_ctrl with a small 16-entry TLB
//   model behind search port 1. A transaction-level model of the port (when it
//   is free, which response is pending, when done is due) is compared against
//   the DUT on every negative edge; directed literal expectations pin the
//   model to hand-derived values.
module tb_tlb_s1_port_ctrl;

  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            lk_req;
  logic [18:0]     lk_vppn;
  logic            lk_va_bit12;
  logic [9:0]      lk_asid;
  logic            lk_gnt;
  logic            lk_rsp_valid;
  logic            lk_rsp_ready;
  logic [36:0]     lk_rsp;
  logic            mt_req;
  logic            mt_is_inv;
  logic [4:0]      mt_invop;
  logic [9:0]      mt_asid;
  logic [18:0]     mt_vppn;
  logic            mt_va_bit12;
  logic            mt_gnt;
  logic            mt_done;
  logic            mt_hit;
  logic [IDXW-1:0] mt_index;
  logic [18:0]     s1_vppn;
  logic            s1_va_bit12;
  logic [9:0]      s1_asid;
  logic            invtlb_valid;
  logic [4:0]      invtlb_op;
  logic [36:0]     s1_result;
  logic [IDXW-1:0] fill_index;

  always #5 clk = ~clk;

  tlb_s1_port_ctrl #(.TLBNUM(16), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .lk_req(lk_req), .lk_vppn(lk_vppn), .lk_va_bit12(lk_va_bit12), .lk_asid(lk_asid),
    .lk_gnt(lk_gnt), .lk_rsp_valid(lk_rsp_valid), .lk_rsp_ready(lk_rsp_ready), .lk_rsp(lk_rsp),
    .mt_req(mt_req), .mt_is_inv(mt_is_inv), .mt_invop(mt_invop), .mt_asid(mt_asid),
    .mt_vppn(mt_vppn), .mt_va_bit12(mt_va_bit12), .mt_gnt(mt_gnt), .mt_done(mt_done),
    .mt_hit(mt_hit), .mt_index(mt_index),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .s1_result(s1_result),
    .fill_index(fill_index)
  );

  // ---------------- TLB model behind port 1 ----------------
  typedef struct packed {
    logic        v;
    logic        g;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
  } tlbe_t;

  tlbe_t tlb [16];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) tlb[i] <= '0;
      tlb[5] <= {1'b1, 1'b0, 10'h003, 19'h00012, 20'h1A2B3, 20'h1A2B4, 2'd3, 2'd1, 1'b1};
      tlb[9] <= {1'b1, 1'b1, 10'h000, 19'h00777, 20'h05555, 20'h05556, 2'd0, 2'd1, 1'b0};
      tlb[2] <= {1'b1, 1'b0, 10'h007, 19'h00030, 20'h00ABC, 20'h00ABD, 2'd1, 2'd0, 1'b1};
    end else if (invtlb_valid) begin
      for (int i = 0; i < 16; i++) begin
        case (invtlb_op)
          5'd0, 5'd1: tlb[i].v <= 1'b0;
          5'd5: if (!tlb[i].g && tlb[i].asid == s1_asid && tlb[i].vppn == s1_vppn)
                  tlb[i].v <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    s1_result = '0;
    for (int i = 15; i >= 0; i--)
      if (tlb[i].v && tlb[i].vppn == s1_vppn && (tlb[i].g || tlb[i].asid == s1_asid))
        s1_result = {1'b1, 4'(i), s1_va_bit12 ? tlb[i].ppn1 : tlb[i].ppn0, 6'd12,
                     tlb[i].plv, tlb[i].mat, tlb[i].d, 1'b1};
  end

  function automatic logic [36:0] tlb_lookup(input logic [18:0] vppn, input logic b12,
                                             input logic [9:0] asid);
    logic [36:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (tlb[i].v && tlb[i].vppn == vppn && (tlb[i].g || tlb[i].asid == asid))
        r = {1'b1, 4'(i), b12 ? tlb[i].ppn1 : tlb[i].ppn0, 6'd12,
             tlb[i].plv, tlb[i].mat, tlb[i].d, 1'b1};
    return r;
  endfunction

  // ---------------- Checking ----------------
  int checks = 0;
  int errors = 0;
  int m_cyc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, m_cyc, $time);
    end
  endtask

  // Transaction-level port model: the port is usable from cycle m_free on
  // unless a lookup response is still waiting for its consumer.
  bit          m_valid = 1'b0;
  int          m_free;
  int          m_done_at;
  int          m_starve;
  bit          m_rsp_held;
  logic [36:0] m_rsp;
  logic        m_hit;
  logic [3:0]  m_idx;
  logic [18:0] m_vppn;
  logic        m_b12;
  logic [9:0]  m_asid;
  logic [7:0]  m_lfsr;

  always @(negedge clk) begin : compare
    bit          free, pick, e_lk, e_mt, e_inv;
    logic [18:0] ev;
    logic        eb;
    logic [9:0]  ea;
    logic [36:0] r;
    free  = !reset && !m_rsp_held && (m_cyc >= m_free);
    pick  = lk_req && !flush && (!mt_req || m_starve == 3);
    e_lk  = free && pick;
    e_mt  = free && mt_req && !pick;
    e_inv = e_mt && mt_is_inv;
    if (e_lk)      begin ev = lk_vppn; eb = lk_va_bit12; ea = lk_asid; end
    else if (e_mt) begin ev = mt_vppn; eb = mt_va_bit12; ea = mt_asid; end
    else           begin ev = m_vppn;  eb = m_b12;       ea = m_asid;  end

    if (m_valid) begin
      check("lk_gnt", lk_gnt, e_lk);
      check("mt_gnt", mt_gnt, e_mt);
      check("invtlb_valid", invtlb_valid, e_inv);
      if (e_inv) check("invtlb_op", invtlb_op, mt_invop);
      check("s1_vppn", s1_vppn, ev);
      check("s1_va_bit12", s1_va_bit12, eb);
      check("s1_asid", s1_asid, ea);
      check("lk_rsp_valid", lk_rsp_valid, m_rsp_held);
      if (m_rsp_held) check("lk_rsp", lk_rsp, m_rsp);
      check("mt_done", mt_done, m_cyc == m_done_at);
      if (m_cyc == m_done_at) begin
        check("mt_hit", mt_hit, m_hit);
        check("mt_index", mt_index, m_idx);
      end
      check("fill_index", fill_index, m_lfsr[3:0]);
      check("fill_nonzero", m_lfsr != 8'h00, 1'b1);
    end

    if (reset) begin
      m_valid    = 1'b1;
      m_free     = m_cyc + 1;
      m_done_at  = -1;
      m_starve   = 0;
      m_rsp_held = 1'b0;
      m_rsp      = '0;
      m_hit      = 1'b0;
      m_idx      = '0;
      m_vppn     = '0;
      m_b12      = 1'b0;
      m_asid     = '0;
      m_lfsr     = 8'h01;
    end else if (m_valid) begin
      if (e_lk) begin
        m_rsp_held = 1'b1;
        m_rsp      = tlb_lookup(ev, eb, ea);
        m_starve   = 0;
        m_free     = m_cyc + 1;
      end else if (m_rsp_held && (lk_rsp_ready || flush)) begin
        m_rsp_held = 1'b0;
      end
      if (e_mt) begin
        r         = tlb_lookup(ev, eb, ea);
        m_hit     = r[36];
        m_idx     = r[35:32];
        m_done_at = m_cyc + 1;
        m_free    = m_cyc + (mt_is_inv ? 3 : 2);
        if (lk_req && m_starve < 3) m_starve++;
      end
      m_vppn = ev;
      m_b12  = eb;
      m_asid = ea;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
    m_cyc++;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          r_first_lk, r_last_lk, r_n_lk;
  int          r_first_mt, r_n_mt;
  int          r_first_done, r_first_inv, r_n_inv, r_n_valid;
  logic        r_done_hit;
  logic [3:0]  r_done_idx;
  logic [36:0] r_rsp;
  bit          r_rsp_seen;

  // Runs n cycles, observing grants. Unless keep is set, a request is
  // dropped after it has been granted, as a real requester would.
  task automatic run(input int n, input bit keep);
    r_first_lk = -1; r_last_lk = -1; r_n_lk = 0;
    r_first_mt = -1; r_n_mt = 0;
    r_first_done = -1; r_first_inv = -1; r_n_inv = 0; r_n_valid = 0;
    r_done_hit = 1'b0; r_done_idx = '0; r_rsp = '0; r_rsp_seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      logic lg, mg;
      @(negedge clk);
      lg = lk_gnt;
      mg = mt_gnt;
      if (lg) begin r_n_lk++; if (r_first_lk < 0) r_first_lk = c; r_last_lk = c; end
      if (mg) begin r_n_mt++; if (r_first_mt < 0) r_first_mt = c; end
      if (invtlb_valid) begin r_n_inv++; if (r_first_inv < 0) r_first_inv = c; end
      if (mt_done && r_first_done < 0) begin
        r_first_done = c; r_done_hit = mt_hit; r_done_idx = mt_index;
      end
      if (lk_rsp_valid) begin
        r_n_valid++;
        if (!r_rsp_seen) begin r_rsp = lk_rsp; r_rsp_seen = 1'b1; end
      end
      tick();
      if (!keep) begin
        if (lg) lk_req = 1'b0;
        if (mg) mt_req = 1'b0;
      end
    end
  endtask

  // ---------------- Directed scenarios ----------------
  initial begin
    logic [3:0] lfsr_seq [4];
    lfsr_seq[0] = 4'h1; lfsr_seq[1] = 4'h2; lfsr_seq[2] = 4'h4; lfsr_seq[3] = 4'h8;

    reset = 1'b1; flush = 1'b0;
    lk_req = 1'b0; lk_vppn = '0; lk_va_bit12 = 1'b0; lk_asid = '0; lk_rsp_ready = 1'b0;
    mt_req = 1'b0; mt_is_inv = 1'b0; mt_invop = '0; mt_asid = '0; mt_vppn = '0;
    mt_va_bit12 = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset values and LFSR start sequence.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("rst_lk_rsp_valid", lk_rsp_valid, 1'b0);
        check("rst_lk_rsp", lk_rsp, 37'd0);
        check("rst_mt_hit", mt_hit, 1'b0);
        check("rst_mt_index", mt_index, 4'd0);
        check("rst_invtlb_op", invtlb_op, 5'd0);
        check("rst_s1_vppn", s1_vppn, 19'd0);
      end
      check("lfsr_seq", fill_index, lfsr_seq[i]);
      tick();
    end

    // Lookup only: entry 5 hit, response held while ready is low.
    lk_vppn = 19'h00012; lk_va_bit12 = 1'b0; lk_asid = 10'h003; lk_rsp_ready = 1'b0;
    lk_req = 1'b1;
    run(4, 1'b0);
    check("lk_gnt_cycle", r_first_lk, 0);
    check("lk_rsp_held_cycles", r_n_valid, 3);
    check("lk_found", r_rsp[36], 1'b1);
    check("lk_index", r_rsp[35:32], 4'd5);
    check("lk_ppn", r_rsp[31:12], 20'h1A2B3);
    lk_rsp_ready = 1'b1;
    tick();
    lk_rsp_ready = 1'b0;

    // tlbsrch miss, then hit on the global entry 9.
    mt_is_inv = 1'b0; mt_vppn = 19'h70000; mt_asid = 10'h003; mt_req = 1'b1;
    run(3, 1'b0);
    check("srch_miss_done_at", r_first_done, 1);
    check("srch_miss_hit", r_done_hit, 1'b0);
    check("srch_miss_no_inv", r_n_inv, 0);
    mt_vppn = 19'h00777; mt_req = 1'b1;
    run(3, 1'b0);
    check("srch_hit_done_at", r_first_done, 1);
    check("srch_hit_hit", r_done_hit, 1'b1);
    check("srch_hit_index", r_done_idx, 4'd9);
    check("srch_hit_no_inv", r_n_inv, 0);

    // invtlb op 5 with a lookup of the same page waiting behind it.
    lk_vppn = 19'h00012; lk_asid = 10'h003; lk_rsp_ready = 1'b1;
    mt_is_inv = 1'b1; mt_invop = 5'h05; mt_asid = 10'h003; mt_vppn = 19'h00012;
    lk_req = 1'b1; mt_req = 1'b1;
    run(6, 1'b0);
    check("inv_mt_gnt", r_first_mt, 0);
    check("inv_valid_at", r_first_inv, 0);
    check("inv_valid_count", r_n_inv, 1);
    check("inv_done_at", r_first_done, 1);
    check("inv_lk_gnt_at", r_first_lk, 3);
    check("inv_lk_found", r_rsp[36], 1'b0);
    mt_is_inv = 1'b0;

    // Starvation: both requests held continuously.
    mt_vppn = 19'h00777; lk_vppn = 19'h00777;
    lk_req = 1'b1; mt_req = 1'b1;
    run(15, 1'b1);
    lk_req = 1'b0; mt_req = 1'b0;
    check("starve_first_mt", r_first_mt, 0);
    check("starve_first_lk", r_first_lk, 6);
    check("starve_second_lk", r_last_lk, 14);
    check("starve_n_lk", r_n_lk, 2);
    check("starve_n_mt", r_n_mt, 6);
    repeat (2) tick();

    // Flush in LK_RSP, in MT_RSP and in IDLE.
    lk_vppn = 19'h00030; lk_asid = 10'h007; lk_rsp_ready = 1'b0; lk_req = 1'b1;
    run(2, 1'b0);
    check("fl_lk_gnt", r_first_lk, 0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_valid_before", lk_rsp_valid, 1'b1);
    tick();
    flush = 1'b0; mt_vppn = 19'h70000; mt_req = 1'b1;
    @(negedge clk);
    check("fl_rsp_dropped", lk_rsp_valid, 1'b0);
    check("fl_idle_mt_gnt", mt_gnt, 1'b1);
    tick();
    mt_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl_mt_done", mt_done, 1'b1);
    tick();
    lk_req = 1'b1;
    @(negedge clk);
    check("fl_blocks_lk", lk_gnt, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fl_lk_after", lk_gnt, 1'b1);
    tick();
    lk_req = 1'b0; lk_rsp_ready = 1'b1;
    tick();
    lk_rsp_ready = 1'b0;

    // Reset with a response pending, mid LFSR sequence.
    lk_vppn = 19'h00777; lk_asid = 10'h003; lk_req = 1'b1;
    run(2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_lk_rsp_valid", lk_rsp_valid, 1'b0);
    check("rst2_fill_index", fill_index, 4'd1);
    check("rst2_lk_rsp", lk_rsp, 37'd0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_s1_port_ctrl.md
# tlb_s1_port_ctrl

Controller for search port 1 of the 16-entry TLB. It shares that single port between two requesters. The first is the EXE-stage load/store address lookup. The second is the maintenance requester, which issues `tlbsrch` and `invtlb`. The block sequences each access as a grant/response handshake, enforces a one-cycle fence after every `invtlb`, and generates the pseudo-random replacement index used by `tlbfill`. It sits between the EXE/WB stages and the TLB's `s1_*` / `invtlb_*` inputs.

## Interface
- TLBNUM, 16, number of TLB entries.
- IDXW, 4, index width (log2 TLBNUM).

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  exception/ertn/refetch flush from WB
- lk_req  in  1  EXE lookup request (level, held until lk_gnt)
- lk_vppn  in  19  lookup VA[31:13]
- lk_va_bit12  in  1  lookup VA[12]
- lk_asid  in  10  current ASID
- lk_gnt  out  1  lookup accepted this cycle
- lk_rsp_valid  out  1  registered lookup result valid
- lk_rsp_ready  in  1  consumer takes result
- lk_rsp  out  37  {found, index[3:0], ppn[19:0], ps[5:0], plv[1:0], mat[1:0], d, v}
- mt_req  in  1  maintenance request (level, held until mt_gnt)
- mt_is_inv  in  1  1 = invtlb, 0 = tlbsrch
- mt_invop  in  5  invtlb op
- mt_asid  in  10  ASID operand (invtlb: rj[9:0]; tlbsrch: CSR.ASID)
- mt_vppn  in  19  VA operand (invtlb: rk[31:13]; tlbsrch: CSR.TLBEHI.VPPN)
- mt_va_bit12  in  1  invtlb rk[12]; 0 for tlbsrch
- mt_gnt  out  1  maintenance op issued this cycle
- mt_done  out  1  one-cycle completion pulse
- mt_hit  out  1  tlbsrch hit (valid with mt_done)
- mt_index  out  IDXW  tlbsrch index (valid with mt_done)
- s1_vppn / s1_va_bit12 / s1_asid  out  19/1/10  to TLB search port 1
- invtlb_valid  out  1  to TLB
- invtlb_op  out  5  to TLB
- s1_result  in  37  TLB port-1 combinational result, same packing as lk_rsp
- fill_index  out  IDXW  replacement index for tlbfill

## Operation
- The FSM has four states: IDLE, LK_RSP, MT_RSP, FENCE.
- IDLE arbitration:
  - mt_req wins by default.
  - lk_req wins instead when starve_cnt == 3.
  - Lookups are granted only in IDLE.
- Maintenance grant (cycle G):
  - Drive s1_* from mt_* and assert mt_gnt.
  - If mt_is_inv: invtlb_valid=1 and invtlb_op=mt_invop, for cycle G only.
  - Capture s1_result.found/index into mt_hit/mt_index.
  - Next state is MT_RSP.
- Lookup grant (cycle G):
  - Drive s1_* from lk_* and assert lk_gnt.
  - Capture s1_result into the lk_rsp register.
  - Next state is LK_RSP.
- Outside a grant cycle, s1_* outputs hold their last driven value and invtlb_valid=0.
- MT_RSP:
  - mt_done=1 for exactly one cycle.
  - Next state is FENCE if the op was invtlb, else IDLE.
- FENCE: no grants for one cycle, then IDLE. This guarantees that no lookup observes a pre-invalidate result.
- LK_RSP:
  - lk_rsp_valid=1 and lk_rsp is held stable.
  - Goes to IDLE on lk_rsp_ready.
- starve_cnt (2-bit):
  - Increments, saturating at 3, when mt is granted while lk_req=1.
  - Clears when lk is granted.
- flush:
  - In LK_RSP: drop the response (lk_rsp_valid→0) and go to IDLE next cycle.
  - In IDLE: suppress the lk grant that cycle; mt grants are still allowed.
  - In MT_RSP/FENCE: no effect; the op has already been performed, so mt_done still pulses.
- fill_index:
  - Low IDXW bits of an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts left every cycle, with new bit0 = q[7]^q[5]^q[4]^q[3].
  - Never all-zero.

## Timing
- Reset values:
  - State is IDLE.
  - lk_gnt, mt_gnt, mt_done, lk_rsp_valid, invtlb_valid, mt_hit all 0.
  - mt_index=0, lk_rsp=0, s1_vppn/s1_va_bit12/s1_asid=0, invtlb_op=0.
  - starve_cnt=0, LFSR=8'h01 (fill_index=1).
- A reset in any state returns to IDLE next edge and discards any pending response.
- Grants are combinational from state and requests in IDLE. Requesters sample the grant at the edge.
- Lookup latency: grant in cycle G, lk_rsp_valid from G+1. Minimum lookup-to-lookup spacing is 2 cycles (G, G+1 with ready=1, next grant at G+2).
- tlbsrch: mt_done at G+1, next grant possible at G+2.
- invtlb: mt_done at G+1, FENCE at G+2, next grant possible at G+3.
- Simultaneous lk_req and mt_req with starve_cnt<3: mt granted, lk waits.

## Test plan
- Lookup only: lk_req with lk_vppn=19'h00012, TLB entry 5 matching, ppn 20'h1A2B3 -> lk_gnt at cycle 0; lk_rsp_valid at cycle 1 with found=1, index=5, ppn=20'h1A2B3; lk_rsp held for 3 cycles with lk_rsp_ready=0.
- tlbsrch miss/hit: mt_is_inv=0 with a non-present VPPN -> mt_done at G+1 with mt_hit=0. Repeat with entry 9 valid -> mt_hit=1, mt_index=9; invtlb_valid stays 0 throughout.
- invtlb + fence: mt_is_inv=1, mt_invop=5'h05, asid=10'h3, with lk_req held -> invtlb_valid=1 at G only; mt_done at G+1; lk_gnt first at G+3; lookup of the invalidated page returns found=0.
- Starvation: mt_req and lk_req both held high continuously -> mt granted 3 times (starve_cnt 1,2,3), then lk_gnt; starve_cnt returns to 0.
- Flush: flush asserted in LK_RSP with lk_rsp_ready=0 -> lk_rsp_valid=0 next cycle, state IDLE. Flush asserted in MT_RSP -> mt_done still 1.
- LFSR: after reset, fill_index sequence over 4 cycles is 1,2,4,8 (LFSR 01,02,04,08). Reset asserted mid-sequence -> fill_index=1 on the next cycle.
